// File: rtl/pipe_stage_bank.sv
// DEPTH-deep bank of pipeline registers carrying data, control, instruction and valid,
// with flush-to-NOP, sticky halt capture and a saturating bubble counter.
module pipe_stage_bank #(
  parameter int                 DATA_W    = 48,
  parameter int                 CTRL_W    = 8,
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800,
  parameter int                 DEPTH     = 1,
  parameter int                 HALT_BIT  = 7,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush,
  input  logic               valid_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [CTRL_W-1:0]  ctrl_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               valid_out,
  output logic [DATA_W-1:0]  data_out,
  output logic [CTRL_W-1:0]  ctrl_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               halted,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam int LAST = DEPTH - 1;

  if (DEPTH < 1 || DEPTH > 4) begin : g_depth_chk
    $error("pipe_stage_bank: DEPTH must be in 1..4");
  end
  if (HALT_BIT < 0 || HALT_BIT >= CTRL_W) begin : g_halt_chk
    $error("pipe_stage_bank: HALT_BIT must index into the control bundle");
  end

  logic [DEPTH-1:0]   valid_q;
  logic [DATA_W-1:0]  data_q  [DEPTH];
  logic [CTRL_W-1:0]  ctrl_q  [DEPTH];
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic               halted_q;
  logic [CNT_W-1:0]   bubble_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        ctrl_q[k]  <= '0;
        instr_q[k] <= NOP_INSTR;
      end
      halted_q <= 1'b0;
      bubble_q <= '0;
    end else if (!halted_q) begin
      if (flush) begin
        for (int k = 0; k < DEPTH; k++) begin
          valid_q[k] <= 1'b0;
          data_q[k]  <= '0;
          ctrl_q[k]  <= '0;
          instr_q[k] <= NOP_INSTR;
        end
      end else if (en) begin
        // Bubbles keep their data but never carry control or a real opcode.
        valid_q[0] <= valid_in;
        data_q[0]  <= data_in;
        ctrl_q[0]  <= valid_in ? ctrl_in : '0;
        instr_q[0] <= valid_in ? instr_in : NOP_INSTR;
        for (int k = 1; k < DEPTH; k++) begin
          valid_q[k] <= valid_q[k-1];
          data_q[k]  <= data_q[k-1];
          ctrl_q[k]  <= ctrl_q[k-1];
          instr_q[k] <= instr_q[k-1];
        end
        if (valid_q[LAST] && ctrl_q[LAST][HALT_BIT]) halted_q <= 1'b1;
        if (!valid_q[LAST] && bubble_q != '1) bubble_q <= bubble_q + CNT_W'(1);
      end
    end
  end

  assign valid_out  = valid_q[LAST];
  assign data_out   = data_q[LAST];
  assign ctrl_out   = valid_q[LAST] ? ctrl_q[LAST] : '0;
  assign instr_out  = rst ? NOP_INSTR : instr_q[LAST];
  assign halted     = halted_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: doc/pipe_stage_bank.md
Name: pipe_stage_bank

Overview:
- Parametrised successor to the fixed MEM/WB latch: a DEPTH-deep bank of pipeline registers carrying a data bundle, a control bundle, the instruction word and a valid bit.
- Adds what the fixed latch lacks: per-stage valid tracking, flush-to-NOP, sticky halt capture, and a saturating bubble counter.
- Used between any two core stages (EX/MEM, MEM/WB, or a multi-cycle memory path when DEPTH>1).

Parameters:
- DATA_W, 48: width of data bundle (e.g. PCInc, MemOut, ALUOut concatenated).
- CTRL_W, 8: width of control bundle (RegDst, RegWrite, MemtoReg, PCtoReg, Cond, Set, Halt, ...).
- INSTR_W, 16: instruction word width.
- NOP_INSTR, 16'h0800: instruction value injected on reset and flush.
- DEPTH, 1: number of register stages, legal 1..4.
- HALT_BIT, 7: index in ctrl bundle of the Halt flag.
- CNT_W, 16: bubble counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance; 0 = stall, all stages hold.
- flush  input  1  squash all stages to NOP on next edge.
- valid_in  input  1  incoming slot carries a real instruction.
- data_in  input  DATA_W  data bundle in.
- ctrl_in  input  CTRL_W  control bundle in.
- instr_in  input  INSTR_W  instruction in.
- valid_out  output  1  last stage valid.
- data_out  output  DATA_W  last stage data.
- ctrl_out  output  CTRL_W  last stage control, forced 0 when valid_out=0.
- instr_out  output  INSTR_W  last stage instruction.
- halted  output  1  sticky: a valid Halt has left the last stage.
- bubble_cnt  output  CNT_W  count of cycles with en=1 and valid_out=0, saturating.

Behaviour:
- All state updates on rising clk; no asynchronous paths except the output masks listed below.
- Reset (rst=1 at edge), all stages:
  - valid=0, data=0, ctrl=0, instr=NOP_INSTR.
  - halted=0, bubble_cnt=0.
- Output mask while rst is high: instr_out=NOP_INSTR combinationally, regardless of register contents.
- Priority per edge: rst > halted freeze > flush > en.
- Halted freeze: when halted=1, every stage holds, flush and en are ignored, bubble_cnt holds. Only rst clears halted.
- flush=1 (not halted), all stages:
  - valid=0, ctrl=0, data=0, instr=NOP_INSTR.
  - flush overrides en=0: a stalled bank is still squashed.
- en=1, no flush:
  - stage0 <= inputs; stage k <= stage k-1.
  - Latency is exactly DEPTH edges from input to output.
  - When valid_in=0, stage0 captures ctrl=0 and instr=NOP_INSTR; data is captured unchanged.
- en=0, no flush: every stage holds.
- ctrl_out = valid_out ? last.ctrl : 0, so no RegWrite or Halt is ever issued from a bubble.
- halted is set on the edge where all of these hold:
  - en=1, flush=0, halted=0;
  - last stage valid;
  - last.ctrl[HALT_BIT]=1.
  - halted rises one edge after that instruction is presented on the outputs.
- bubble_cnt increments on an edge with en=1, flush=0, halted=0, valid_out=0. It saturates at 2^CNT_W-1 with no wrap. Flush edges do not count.
- DEPTH=1 is functionally the legacy latch plus valid, flush and halt.
- DEPTH outside 1..4 is a compile-time error.
- Reset mid-stall or mid-flush: reset wins, and the state after reset is identical to power-up.

Test Plan:
- Reset: rst=1 for 2 cycles with instr_in=16'hFFFF and valid_in=1 -> instr_out=16'h0800 while rst is high and after release; valid_out=0, ctrl_out=0, halted=0, bubble_cnt=0.
- Latency: DEPTH=3, en=1; feed valid instrs A=16'h1234, B=16'h5678 on consecutive cycles -> A appears on instr_out exactly 3 edges later and B on the following edge, with valid_out=1 for both.
- Stall: DEPTH=2 holding A in stage1 and B in stage0; en=0 for 4 cycles -> outputs stay A, bubble_cnt unchanged. On en=1, B appears next edge.
- Flush beats stall: bank full, en=0, flush=1 -> next edge all stages NOP, valid_out=0, ctrl_out=0. The following en=1 edge with valid_out=0 increments bubble_cnt by 1.
- Halt: DEPTH=1, valid instr with ctrl_in[7]=1 and en=1:
  - after edge 1, valid_out=1 and ctrl_out[7]=1;
  - after edge 2, halted=1;
  - further flush=1 or new inputs leave all outputs frozen until rst.
- Saturation: CNT_W=4, 20 bubble cycles with en=1 and valid_in=0 -> bubble_cnt stops at 15.
